// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller and its priority encoder.
// State encodings and vector defaults live here so later bus blocks can reuse them.
package intr_ctrl_pkg;

  localparam int         NSRC_MAX         = 8;
  localparam logic [7:0] VEC_BASE_DEFAULT = 8'h20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
// Reports whether any request is present and the 3-bit index of the winner.
module prio_enc
  import intr_ctrl_pkg::*;
#(
  parameter int N = NSRC_MAX
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [2:0]   o_idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_valid = |i_req;
    o_idx   = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Priority interrupt controller driving the CPU's single intr/vector input.
// Edge-detects device requests, arbitrates by fixed priority, and runs the inta/eoi handshake.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int         NSRC     = 8,
  parameter logic [7:0] VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NSRC-1:0] irq,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            eoi,
  input  logic            inta,
  output logic            intr,
  output logic [7:0]      vector,
  output logic [NSRC-1:0] mask,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] isr
);

  state_t          r_state;
  state_t          w_stateNext;
  logic [NSRC-1:0] r_irqD;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_isr;
  logic            r_intr;
  logic [7:0]      r_vector;
  logic [2:0]      r_winner;

  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_elig;
  logic [NSRC-1:0] w_maskNext;
  logic [NSRC-1:0] w_pendingNext;
  logic [NSRC-1:0] w_pendClr;
  logic [NSRC-1:0] w_isrNext;
  logic [NSRC-1:0] w_winnerBit;
  logic            w_intrNext;
  logic [7:0]      w_vectorNext;
  logic [2:0]      w_winnerNext;
  logic [2:0]      w_idx;
  logic            w_valid;
  logic            w_stillElig;

  assign w_edge      = irq & ~r_irqD;
  assign w_elig      = r_pending & ~r_mask;
  assign w_maskNext  = mask_we ? mask_wdata : r_mask;
  assign w_winnerBit = NSRC'(1) << r_winner;
  // The withdraw test looks at the incoming mask so a masking write drops intr right away.
  assign w_stillElig = |(w_winnerBit & r_pending & ~w_maskNext);

  prio_enc #(.N(NSRC)) u_prio_enc (
    .i_req   (w_elig),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_stateNext  = r_state;
    w_intrNext   = r_intr;
    w_vectorNext = r_vector;
    w_winnerNext = r_winner;
    w_isrNext    = r_isr;
    w_pendClr    = '0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_stateNext  = REQ;
          w_intrNext   = 1'b1;
          w_vectorNext = VEC_BASE + {5'd0, w_idx};
          w_winnerNext = w_idx;
        end
      end
      REQ: begin
        if (inta) begin
          w_stateNext = SERVICE;
          w_intrNext  = 1'b0;
          w_isrNext   = w_winnerBit;
          w_pendClr   = w_winnerBit;
        end else if (!w_stillElig) begin
          w_stateNext = IDLE;
          w_intrNext  = 1'b0;
        end
      end
      SERVICE: begin
        if (eoi) begin
          w_stateNext = IDLE;
          w_isrNext   = '0;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_intrNext  = 1'b0;
      end
    endcase
    // A fresh edge outranks the acknowledge clear on the same bit.
    w_pendingNext = (r_pending & ~w_pendClr) | w_edge;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= IDLE;
      r_irqD    <= '0;
      r_mask    <= '1;
      r_pending <= '0;
      r_isr     <= '0;
      r_intr    <= 1'b0;
      r_vector  <= 8'h00;
      r_winner  <= 3'd0;
    end else begin
      r_state   <= w_stateNext;
      r_irqD    <= irq;
      r_mask    <= w_maskNext;
      r_pending <= w_pendingNext;
      r_isr     <= w_isrNext;
      r_intr    <= w_intrNext;
      r_vector  <= w_vectorNext;
      r_winner  <= w_winnerNext;
    end
  end

  assign intr    = r_intr;
  assign vector  = r_vector;
  assign mask    = r_mask;
  assign pending = r_pending;
  assign isr     = r_isr;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: table of per-cycle vectors plus hand-written
// sequences for asynchronous reset and the ack-versus-mask race.
module tb_intr_ctrl;

  typedef struct {
    logic [7:0] irq;
    logic       maskWe;
    logic [7:0] maskWdata;
    logic       eoi;
    logic       inta;
    logic       expIntr;
    logic [7:0] expVector;
    logic [7:0] expMask;
    logic [7:0] expPending;
    logic [7:0] expIsr;
  } vec_t;

  logic       clk;
  logic       clr;
  logic [7:0] irq;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       eoi;
  logic       inta;
  logic       intr;
  logic [7:0] vector;
  logic [7:0] mask;
  logic [7:0] pending;
  logic [7:0] isr;

  int   assertCount;
  int   failCount;
  int   curStep;
  vec_t vecs[$];

  intr_ctrl #(.NSRC(8), .VEC_BASE(8'h20)) dut (
    .clk        (clk),
    .clr        (clr),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .eoi        (eoi),
    .inta       (inta),
    .intr       (intr),
    .vector     (vector),
    .mask       (mask),
    .pending    (pending),
    .isr        (isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at step %0d: got %h, expected %h", name, curStep, act, exp);
    end
  endtask

  task automatic addVec(input logic [7:0] i, input logic we, input logic [7:0] wd,
                        input logic e, input logic a, input logic xi, input logic [7:0] xv,
                        input logic [7:0] xm, input logic [7:0] xp, input logic [7:0] xs);
    vec_t v;
    v.irq = i; v.maskWe = we; v.maskWdata = wd; v.eoi = e; v.inta = a;
    v.expIntr = xi; v.expVector = xv; v.expMask = xm; v.expPending = xp; v.expIsr = xs;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs on the falling edge, then check just after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    irq        = v.irq;
    mask_we    = v.maskWe;
    mask_wdata = v.maskWdata;
    eoi        = v.eoi;
    inta       = v.inta;
    @(posedge clk);
    #1;
    checkOutput("intr",    {7'd0, intr}, {7'd0, v.expIntr});
    checkOutput("vector",  vector,  v.expVector);
    checkOutput("mask",    mask,    v.expMask);
    checkOutput("pending", pending, v.expPending);
    checkOutput("isr",     isr,     v.expIsr);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_intr"},    {7'd0, intr}, 8'h00);
    checkOutput({tag, "_vector"},  vector,  8'h00);
    checkOutput({tag, "_mask"},    mask,    8'hFF);
    checkOutput({tag, "_pending"}, pending, 8'h00);
    checkOutput({tag, "_isr"},     isr,     8'h00);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    curStep     = -1;
    clr         = 1'b1;
    irq         = 8'h00;
    mask_we     = 1'b0;
    mask_wdata  = 8'h00;
    eoi         = 1'b0;
    inta        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    clr = 1'b0;

    //      irq   we wd    eoi inta intr vec    mask   pend   isr
    // Single source 3: request, ack, end of interrupt.
    addVec(8'h00, 1, 8'h00, 0, 0,  0, 8'h00, 8'h00, 8'h00, 8'h00);
    addVec(8'h08, 0, 8'h00, 0, 0,  0, 8'h00, 8'h00, 8'h08, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  1, 8'h23, 8'h00, 8'h08, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  1, 8'h23, 8'h00, 8'h08, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 1,  0, 8'h23, 8'h00, 8'h00, 8'h08);
    addVec(8'h00, 0, 8'h00, 0, 0,  0, 8'h23, 8'h00, 8'h00, 8'h08);
    addVec(8'h00, 0, 8'h00, 1, 0,  0, 8'h23, 8'h00, 8'h00, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  0, 8'h23, 8'h00, 8'h00, 8'h00);
    // Sources 5 and 1 together: 1 first, then 5 two cycles after eoi.
    addVec(8'h22, 0, 8'h00, 0, 0,  0, 8'h23, 8'h00, 8'h22, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  1, 8'h21, 8'h00, 8'h22, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 1,  0, 8'h21, 8'h00, 8'h20, 8'h02);
    addVec(8'h00, 0, 8'h00, 1, 0,  0, 8'h21, 8'h00, 8'h20, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  1, 8'h25, 8'h00, 8'h20, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 1,  0, 8'h25, 8'h00, 8'h00, 8'h20);
    addVec(8'h00, 0, 8'h00, 1, 0,  0, 8'h25, 8'h00, 8'h00, 8'h00);
    // Source 0 arrives while source 4 is in REQ: vector stays frozen.
    addVec(8'h10, 0, 8'h00, 0, 0,  0, 8'h25, 8'h00, 8'h10, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  1, 8'h24, 8'h00, 8'h10, 8'h00);
    addVec(8'h01, 0, 8'h00, 0, 0,  1, 8'h24, 8'h00, 8'h11, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  1, 8'h24, 8'h00, 8'h11, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 1,  0, 8'h24, 8'h00, 8'h01, 8'h10);
    addVec(8'h00, 0, 8'h00, 1, 0,  0, 8'h24, 8'h00, 8'h01, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  1, 8'h20, 8'h00, 8'h01, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 1,  0, 8'h20, 8'h00, 8'h00, 8'h01);
    addVec(8'h00, 0, 8'h00, 1, 0,  0, 8'h20, 8'h00, 8'h00, 8'h00);
    // Masking source 2 in REQ withdraws; unmasking re-raises it.
    addVec(8'h04, 0, 8'h00, 0, 0,  0, 8'h20, 8'h00, 8'h04, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  1, 8'h22, 8'h00, 8'h04, 8'h00);
    addVec(8'h00, 1, 8'h04, 0, 0,  0, 8'h22, 8'h04, 8'h04, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  0, 8'h22, 8'h04, 8'h04, 8'h00);
    addVec(8'h00, 1, 8'h00, 0, 0,  0, 8'h22, 8'h00, 8'h04, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  1, 8'h22, 8'h00, 8'h04, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 1,  0, 8'h22, 8'h00, 8'h00, 8'h04);
    addVec(8'h00, 0, 8'h00, 1, 0,  0, 8'h22, 8'h00, 8'h00, 8'h00);
    // Source 0 during SERVICE of source 6: no nesting, spurious inta ignored.
    addVec(8'h40, 0, 8'h00, 0, 0,  0, 8'h22, 8'h00, 8'h40, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  1, 8'h26, 8'h00, 8'h40, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 1,  0, 8'h26, 8'h00, 8'h00, 8'h40);
    addVec(8'h01, 0, 8'h00, 0, 0,  0, 8'h26, 8'h00, 8'h01, 8'h40);
    addVec(8'h00, 0, 8'h00, 0, 1,  0, 8'h26, 8'h00, 8'h01, 8'h40);
    addVec(8'h00, 0, 8'h00, 1, 0,  0, 8'h26, 8'h00, 8'h01, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  1, 8'h20, 8'h00, 8'h01, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 1,  0, 8'h20, 8'h00, 8'h00, 8'h01);
    addVec(8'h00, 0, 8'h00, 1, 0,  0, 8'h20, 8'h00, 8'h00, 8'h00);
    // New edge on source 3 coincident with its inta stays pending.
    addVec(8'h08, 0, 8'h00, 0, 0,  0, 8'h20, 8'h00, 8'h08, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  1, 8'h23, 8'h00, 8'h08, 8'h00);
    addVec(8'h08, 0, 8'h00, 0, 1,  0, 8'h23, 8'h00, 8'h08, 8'h08);
    addVec(8'h00, 0, 8'h00, 0, 0,  0, 8'h23, 8'h00, 8'h08, 8'h08);
    addVec(8'h00, 0, 8'h00, 1, 0,  0, 8'h23, 8'h00, 8'h08, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  1, 8'h23, 8'h00, 8'h08, 8'h00);

    for (int k = 0; k < vecs.size(); k++) begin
      curStep = k;
      applyStimulus(vecs[k]);
    end

    // Reset while in REQ must clear everything before the next rising edge.
    curStep = 1000;
    @(negedge clk);
    clr = 1'b1;
    #1;
    checkResetState("async_clr");
    @(posedge clk);
    #1;
    checkResetState("held_clr");
    @(negedge clk);
    clr = 1'b0;

    // Ack in the same cycle as a write that masks the winner: the ack wins.
    vecs.delete();
    addVec(8'h00, 1, 8'h00, 0, 0,  0, 8'h00, 8'h00, 8'h00, 8'h00);
    addVec(8'h01, 0, 8'h00, 0, 0,  0, 8'h00, 8'h00, 8'h01, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  1, 8'h20, 8'h00, 8'h01, 8'h00);
    addVec(8'h00, 1, 8'h01, 0, 1,  0, 8'h20, 8'h01, 8'h00, 8'h01);
    addVec(8'h00, 0, 8'h00, 1, 0,  0, 8'h20, 8'h01, 8'h00, 8'h00);
    addVec(8'h00, 0, 8'h00, 0, 0,  0, 8'h20, 8'h01, 8'h00, 8'h00);
    for (int k = 0; k < vecs.size(); k++) begin
      curStep = 2000 + k;
      applyStimulus(vecs[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Priority interrupt controller in front of the pipelined CPU's single interrupt input.
- Collects NSRC edge-triggered device requests and holds a per-source mask.
- Raises intr with a stable 8-bit vector, completes the inta handshake, then holds off further requests until the handler signals end-of-interrupt (eoi).
- Drives the CPU's intr/vector inputs and consumes its inta output.

Parameters:
- NSRC, 8, number of interrupt sources (1..8).
- VEC_BASE, 8'h20, vector issued for source 0; source i issues VEC_BASE+i, modulo 256.

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  asynchronous, active-high reset
- irq  in  NSRC  device requests, synchronous to clk, rising edge = request
- mask_we  in  1  mask register write strobe
- mask_wdata  in  NSRC  new mask value (1 = source disabled)
- eoi  in  1  one-cycle end-of-interrupt pulse from the handler
- inta  in  1  CPU interrupt acknowledge, one-cycle pulse
- intr  out  1  interrupt request to CPU (registered)
- vector  out  8  interrupt vector to CPU (registered)
- mask  out  NSRC  current mask register
- pending  out  NSRC  latched pending requests
- isr  out  NSRC  in-service bit, one-hot or zero

Behaviour:
- Reset: intr=0, vector=8'h00, mask=all ones, pending=0, isr=0, irq_d=0, state=IDLE. Reset mid-operation drops intr immediately and abandons any request or service.
- Edge detect: irq_d<=irq. Pending bit i is set when irq[i]&~irq_d[i].
  - An edge at cycle n shows in pending at n+1.
  - Set beats clear in the same cycle, so a new edge on the bit being acknowledged stays pending.
- Mask: mask<=mask_wdata when mask_we=1. Masked sources still latch into pending but are not eligible.
- Eligible set = pending & ~mask. Winner = lowest set index (fixed priority, bit 0 highest).
- State machine (IDLE, REQ, SERVICE):
  - IDLE: if eligible!=0, go to REQ, intr<=1, vector<=VEC_BASE+winner, and latch winner index. intr rises 1 cycle after eligibility. inta and eoi are ignored.
  - REQ:
    - vector and winner are frozen; a higher-priority arrival does not change them.
    - On inta=1: clear pending[winner] unless a new edge arrives the same cycle, set isr[winner], intr<=0, go to SERVICE. vector holds its value.
    - Otherwise, if pending[winner]&~mask[winner] becomes 0 (mask write): withdraw, intr<=0, return to IDLE.
    - inta in the same cycle as a masking write: the ack wins.
    - eoi is ignored.
  - SERVICE:
    - No nesting: intr stays 0 regardless of pending.
    - On eoi=1: isr<=0, go to IDLE. Re-arbitration happens in IDLE, so the next intr rises 2 cycles after eoi at the earliest.
    - inta is ignored (spurious).
- inta and eoi are single-cycle pulses; a level held high acts only once per state entry.
- vector keeps its last value outside REQ/SERVICE; the CPU samples it only on inta.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, REQ=2'd1, SERVICE=2'd2;
  - VEC_BASE default;
  - the NSRC maximum of 8.
- One sub-module, prio_enc: combinational lowest-index-first encoder, NSRC in → valid + 3-bit index out. It is reused by later bus arbiters.
- Everything else lives in intr_ctrl.

Test Plan:
- Reset then mask_wdata=8'h00; pulse irq[3] at cycle 10 → pending[3]=1 at 11, intr=1 with vector=8'h23 at 12. inta at 14 → intr=0, isr=8'h08, pending=0 at 15. eoi at 20 → isr=0, state IDLE at 21.
- irq[5] and irq[1] edges in the same cycle → vector=8'h21 first. After inta+eoi, second request with vector=8'h25, intr high 2 cycles after eoi.
- While in REQ for source 4 (vector 8'h24), irq[0] edge → vector stays 8'h24 until inta. After eoi, vector=8'h20 is issued.
- In REQ for source 2, mask_we with mask_wdata=8'h04 → intr drops next cycle, pending[2] stays 1. Unmask → request re-raised with vector=8'h22.
- In SERVICE for source 6, irq[0] edge → intr stays 0 and pending[0]=1. Spurious inta gives no change. eoi → intr with vector=8'h20.
- New irq[3] edge in the same cycle as inta for source 3 → pending[3] stays 1, second request after eoi. Assert clr mid-REQ → all outputs return to reset values asynchronously, before the next clk edge.
